pixel_ram_sched: RTL and testbench
==================================

Name: pixel_ram_sched

Overview:
- Frame-level controller for the pixel block RAM feeding the cascaded SVM datapath.
- Sequences each frame in two phases:
  - LOAD: accepts NUM_OF_PIXELS pixels over a valid/ready input and writes them to the RAM.
  - STREAM: reads them back in address order and presents them over a valid/ready output with backpressure.
- Replaces ad-hoc we/re/stall sequencing with a single FSM owning all RAM control.

Parameters:
XLEN_PIXEL, 8, pixel width in bits
NUM_OF_PIXELS, 4, pixels per frame; must be >=1 and <= 2**ADDR_WIDTH
ADDR_WIDTH, 10, RAM address width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a frame; sampled only in IDLE
in_valid  input  1  load pixel valid
in_data  input  XLEN_PIXEL  load pixel
in_ready  output  1  controller accepts in_data
ram_we  output  1  RAM write enable
ram_addr_write  output  ADDR_WIDTH  RAM write address
ram_di  output  XLEN_PIXEL  RAM write data
ram_re  output  1  RAM read enable
ram_addr_read  output  ADDR_WIDTH  RAM read address
ram_do  input  XLEN_PIXEL  RAM read data, valid one cycle after ram_re
out_valid  output  1  streamed pixel valid
out_data  output  XLEN_PIXEL  streamed pixel
out_last  output  1  high with the final pixel of the frame
out_ready  input  1  downstream accepts out_data
busy  output  1  high in LOAD, STREAM and DONE
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset: every output is 0; FSM in IDLE; all counters and the output buffer are cleared. An asserted rst_n mid-frame aborts immediately. RAM contents are untouched.
- FSM states: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - start=1 moves to LOAD next cycle and clears wr_cnt and rd_cnt.
  - Other inputs are ignored.
- LOAD:
  - in_ready=1 combinationally.
  - Accept = in_valid & in_ready. On accept in the same cycle: ram_we=1, ram_addr_write=wr_cnt, ram_di=in_data; wr_cnt increments.
  - On the accept with wr_cnt==NUM_OF_PIXELS-1, go to STREAM next cycle.
  - in_ready is 0 from that point on.
- STREAM:
  - 2-entry output FIFO; out_valid = FIFO non-empty; out_data/out_last taken from the head.
  - pop = out_valid & out_ready.
  - Read issue (combinational): ram_re=1, ram_addr_read=rd_cnt when rd_cnt<NUM_OF_PIXELS and (fifo_count - pop + pending) < 2.
  - pending is a 1-bit register equal to the previous cycle's ram_re.
  - On ram_re, rd_cnt increments.
  - When pending=1, ram_do is pushed into the FIFO, tagged last if it came from address NUM_OF_PIXELS-1.
  - Push and pop in the same cycle leave the count unchanged.
  - Full throughput is one pixel per cycle when out_ready is held high.
  - First out_valid appears 2 cycles after entering STREAM.
  - Pop of the last-tagged entry moves to DONE next cycle.
- DONE: done=1 for exactly one cycle, then IDLE; busy=1 during DONE.
- start while busy is ignored.
- in_valid outside LOAD is ignored, with no RAM write.
- out_ready outside STREAM has no effect.
- ram_we and ram_re are never high in the same cycle.
- Counters are ADDR_WIDTH+1 bits, so NUM_OF_PIXELS=2**ADDR_WIDTH does not wrap.
- Address outputs show the counter value while their enable is low and return to 0 on IDLE entry.

Test Plan:
- Basic frame: NUM_OF_PIXELS=4; pulse start, then drive 0x11,0x22,0x33,0x44 with in_valid held high and out_ready high -> writes at addresses 0..3 on 4 consecutive cycles; output 0x11,0x22,0x33,0x44 on consecutive cycles with out_last only on 0x44; done pulses one cycle later; busy falls.
- Input gaps: deassert in_valid every other cycle -> ram_we only on accepted cycles, addresses contiguous 0..3, no duplicate or skipped writes.
- Backpressure: out_ready low for 5 cycles after first out_valid -> FIFO holds 2 entries, ram_re stays low, out_data stable at 0x11; on release the stream resumes 0x11..0x44 in order with no loss.
- Start during busy: pulse start mid-LOAD -> ignored; the frame completes normally and a single done pulse is produced.
- Reset mid-STREAM: drive rst_n low after 2 pixels popped -> all outputs 0 immediately, FSM IDLE; a new start then runs a full frame from address 0.
- Max size: ADDR_WIDTH=2, NUM_OF_PIXELS=4 -> last write at address 3, last read at address 3, counters do not wrap, out_last asserted correctly.

Source files
------------

// File: rtl/pixel_ram_sched.sv
// Frame controller for the pixel block RAM: loads one frame over a valid/ready
// input, then streams it back in address order through a 2-entry output FIFO.
module pixel_ram_sched #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 4,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [XLEN_PIXEL-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_write,
  output logic [XLEN_PIXEL-1:0] ram_di,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr_read,
  input  logic [XLEN_PIXEL-1:0] ram_do,
  output logic                  out_valid,
  output logic [XLEN_PIXEL-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // One spare counter bit so a frame filling the whole RAM ends without wrapping.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] NUM_PIX  = CW'(NUM_OF_PIXELS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OF_PIXELS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t                state;
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         rd_cnt;
  logic                  pending;
  logic                  pending_last;
  logic [XLEN_PIXEL-1:0] fifo_data [2];
  logic [1:0]            fifo_tag;
  logic                  fifo_wptr;
  logic                  fifo_rptr;
  logic [1:0]            fifo_count;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic [2:0]            occupancy;

  // Handshakes: a beat transfers on a cycle where valid and ready are both high;
  // valid never waits on ready, and ready is a function of state only.
  assign in_ready       = (state == S_LOAD);
  assign accept         = in_valid & in_ready;
  assign ram_we         = accept;
  assign ram_addr_write = wr_cnt[ADDR_WIDTH-1:0];
  assign ram_di         = accept ? in_data : '0;

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = out_valid ? fifo_data[fifo_rptr] : '0;
  assign out_last  = out_valid & fifo_tag[fifo_rptr];
  assign pop       = out_valid & out_ready & (state == S_STREAM);
  assign push      = pending;

  // Entries held plus the read in flight, after this cycle's pop, must leave a free slot.
  assign occupancy     = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, pending};
  assign ram_re        = (state == S_STREAM) && (rd_cnt < NUM_PIX) && (occupancy < 3'd2);
  assign ram_addr_read = rd_cnt[ADDR_WIDTH-1:0];

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_tag     <= '0;
      fifo_wptr    <= 1'b0;
      fifo_rptr    <= 1'b0;
      fifo_count   <= '0;
    end else begin
      pending      <= ram_re;
      pending_last <= ram_re && (rd_cnt == LAST_IDX);
      if (accept) wr_cnt <= wr_cnt + CNT_ONE;
      if (ram_re) rd_cnt <= rd_cnt + CNT_ONE;

      if (push) begin
        fifo_data[fifo_wptr] <= ram_do;
        fifo_tag[fifo_wptr]  <= pending_last;
        fifo_wptr            <= ~fifo_wptr;
      end
      if (pop) fifo_rptr <= ~fifo_rptr;
      if (push && !pop)      fifo_count <= fifo_count + 2'd1;
      else if (pop && !push) fifo_count <= fifo_count - 2'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_LOAD;
            wr_cnt <= '0;
            rd_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (accept && (wr_cnt == LAST_IDX)) state <= S_STREAM;
        end
        S_STREAM: begin
          if (pop && out_last) state <= S_DONE;
        end
        S_DONE: begin
          // Park address outputs at 0 and drop any FIFO residue before idling.
          state      <= S_IDLE;
          wr_cnt     <= '0;
          rd_cnt     <= '0;
          pending    <= 1'b0;
          fifo_wptr  <= 1'b0;
          fifo_rptr  <= 1'b0;
          fifo_count <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_ram_sched.sv
// Bench for pixel_ram_sched: two instances (10-bit and 2-bit address RAMs, 4-pixel
// frames) share stimulus and are checked every cycle against a transaction-level model.
module tb_pixel_ram_sched;

  localparam int N = 4;

  typedef enum int {P_IDLE, P_LOAD, P_STREAM, P_DONE} phase_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic [1:0]       d_in_ready, d_we, d_re, d_ov, d_ol, d_busy, d_done;
  logic [1:0][9:0]  d_aw, d_ar;
  logic [1:0][7:0]  d_di, d_od;
  logic [1:0][1:0]  d_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model state
  phase_t     m_phase = P_IDLE;
  int         m_acc, m_rd, m_rd_lag, m_pop;
  logic [7:0] exp_q[$];
  logic       exp_in_ready, exp_we, exp_ov, exp_pop, exp_re, exp_ol, exp_busy, exp_done;

  // Per-frame logs of instance 0 for the directed checks
  logic [7:0] got_q[$];
  int         pop_cyc[$];
  logic [9:0] wr_aq[$];
  int         wr_cyc[$];
  int         done_seen;
  int         rd_n [2];
  int         first_valid_delay;
  int         stream_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int AW = (g == 0) ? 10 : 2;
    logic [AW-1:0] aw;
    logic [AW-1:0] ar;
    logic [7:0]    rdo;
    logic [7:0]    mem [0:(1<<AW)-1];

    pixel_ram_sched #(
      .XLEN_PIXEL(8), .NUM_OF_PIXELS(N), .ADDR_WIDTH(AW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(d_in_ready[g]), .ram_we(d_we[g]), .ram_addr_write(aw), .ram_di(d_di[g]),
      .ram_re(d_re[g]), .ram_addr_read(ar), .ram_do(rdo), .out_valid(d_ov[g]),
      .out_data(d_od[g]), .out_last(d_ol[g]), .out_ready(out_ready), .busy(d_busy[g]),
      .done(d_done[g]), .state_dbg(d_state[g])
    );

    assign d_aw[g] = 10'(aw);
    assign d_ar[g] = 10'(ar);

    // Synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
      if (d_we[g]) mem[aw] <= d_di[g];
      if (d_re[g]) rdo <= mem[ar];
    end
  end

  task automatic chk(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=0x%0h expected=0x%0h", name, g, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    pop_cyc.delete();
    wr_aq.delete();
    wr_cyc.delete();
    done_seen         = 0;
    rd_n[0]           = 0;
    rd_n[1]           = 0;
    first_valid_delay = -1;
    stream_cyc        = 0;
  endtask

  // Compare process: samples 1ns before each rising edge, then advances the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (!rst_n) begin
        for (int g = 0; g < 2; g++)
          chk("reset_outputs_zero", g,
              32'(|{d_in_ready[g], d_we[g], d_aw[g], d_di[g], d_re[g], d_ar[g],
                    d_ov[g], d_od[g], d_ol[g], d_busy[g], d_done[g]}), 32'd0);
        m_phase  = P_IDLE;
        m_acc    = 0;
        m_rd     = 0;
        m_rd_lag = 0;
        m_pop    = 0;
        exp_q.delete();
      end else begin
        exp_in_ready = (m_phase == P_LOAD);
        exp_we       = in_valid && exp_in_ready;
        exp_ov       = (m_phase == P_STREAM) && (m_rd_lag > m_pop);
        exp_pop      = exp_ov && out_ready;
        exp_re       = (m_phase == P_STREAM) && (m_rd < N) &&
                       ((m_rd - m_pop - (exp_pop ? 1 : 0)) < 2);
        exp_ol       = exp_ov && (m_pop == N - 1);
        exp_busy     = (m_phase != P_IDLE);
        exp_done     = (m_phase == P_DONE);

        for (int g = 0; g < 2; g++) begin
          chk("busy", g, 32'(d_busy[g]), 32'(exp_busy));
          chk("done", g, 32'(d_done[g]), 32'(exp_done));
          chk("in_ready", g, 32'(d_in_ready[g]), 32'(exp_in_ready));
          chk("ram_we", g, 32'(d_we[g]), 32'(exp_we));
          chk("ram_re", g, 32'(d_re[g]), 32'(exp_re));
          chk("out_valid", g, 32'(d_ov[g]), 32'(exp_ov));
          if (exp_we) begin
            chk("ram_addr_write", g, 32'(d_aw[g]), 32'(m_acc));
            chk("ram_di", g, 32'(d_di[g]), 32'(in_data));
          end
          if (exp_re) chk("ram_addr_read", g, 32'(d_ar[g]), 32'(m_rd));
          if (exp_ov) begin
            chk("out_data", g, 32'(d_od[g]), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hDEAD);
            chk("out_last", g, 32'(d_ol[g]), 32'(exp_ol));
          end
          if (m_phase == P_IDLE) begin
            chk("idle_addr_write", g, 32'(d_aw[g]), 32'd0);
            chk("idle_addr_read", g, 32'(d_ar[g]), 32'd0);
          end
          if (d_re[g]) rd_n[g]++;
        end

        if (d_done[0]) done_seen++;
        if (d_we[0]) begin
          wr_aq.push_back(d_aw[0]);
          wr_cyc.push_back(cyc);
        end
        if (d_ov[0] && out_ready) begin
          got_q.push_back(d_od[0]);
          pop_cyc.push_back(cyc);
        end
        if (m_phase == P_STREAM) begin
          if (d_ov[0] && first_valid_delay < 0) first_valid_delay = stream_cyc;
          stream_cyc++;
        end

        if (exp_we) begin
          exp_q.push_back(in_data);
          m_acc++;
        end
        if (exp_pop) begin
          void'(exp_q.pop_front());
          m_pop++;
        end
        m_rd_lag = m_rd;
        if (exp_re) m_rd++;

        case (m_phase)
          P_IDLE: if (start) begin
            m_phase  = P_LOAD;
            m_acc    = 0;
            m_rd     = 0;
            m_rd_lag = 0;
            m_pop    = 0;
            exp_q.delete();
          end
          P_LOAD:   if (exp_we && m_acc == N) m_phase = P_STREAM;
          P_STREAM: if (exp_pop && m_pop == N) m_phase = P_DONE;
          default:  m_phase = P_IDLE;
        endcase
      end
    end
  end

  task automatic reset_dut();
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("post_reset_busy", g, 32'(d_busy[g]), 32'd0);
      chk("post_reset_done", g, 32'(d_done[g]), 32'd0);
      chk("post_reset_in_ready", g, 32'(d_in_ready[g]), 32'd0);
    end
  endtask

  task automatic load_frame(input logic [7:0] px [4], input bit gaps, input bit start_mid);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = px[i];
      start    = start_mid && (i == 1);
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hBB;
  endtask

  task automatic run_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                           input logic [7:0] p3, input bit gaps, input int bp,
                           input bit start_mid);
    logic [7:0] px [4];
    int k;
    px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3;
    clear_logs();
    out_ready = (bp == 0);
    load_frame(px, gaps, start_mid);

    if (bp > 0) begin
      for (k = 0; k < 20; k++) begin
        #1;
        if (d_ov[0]) break;
        @(negedge clk);
      end
      chk("first_valid_timeout", 0, 32'(k < 20), 32'd1);
      for (int c = 0; c < bp; c++) begin
        chk("bp_out_valid", 0, 32'(d_ov[0]), 32'd1);
        chk("bp_out_data", 0, 32'(d_od[0]), 32'(p0));
        chk("bp_ram_re", 0, 32'(d_re[0]), 32'd0);
        @(negedge clk);
        #1;
      end
      out_ready = 1'b1;
    end
    if (start_mid) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (d_done[0]) break;
    end
    chk("done_timeout", 0, 32'(k < 60), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    chk("busy_after_done", 0, 32'(d_busy[0]), 32'd0);
    chk("busy_after_done", 1, 32'(d_busy[1]), 32'd0);

    chk("stream_len", 0, 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk("stream_px", i, 32'(got_q[i]), 32'(px[i]));
    chk("write_count", 0, 32'(wr_aq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < wr_aq.size()) chk("write_addr", i, 32'(wr_aq[i]), 32'(i));
    chk("done_pulses", 0, 32'(done_seen), 32'd1);
    chk("read_count", 0, 32'(rd_n[0]), 32'd4);
    chk("read_count", 1, 32'(rd_n[1]), 32'd4);
    if (wr_cyc.size() == 4)
      chk("write_span", 0, 32'(wr_cyc[3] - wr_cyc[0]), gaps ? 32'd6 : 32'd3);
    if (!gaps && bp == 0) begin
      chk("first_valid_delay", 0, 32'(first_valid_delay), 32'd2);
      if (pop_cyc.size() == 4) chk("pop_span", 0, 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
    end
  endtask

  task automatic reset_mid_stream();
    logic [7:0] px [4];
    int k;
    px[0] = 8'hC1; px[1] = 8'hC2; px[2] = 8'hC3; px[3] = 8'hC4;
    clear_logs();
    out_ready = 1'b1;
    load_frame(px, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (got_q.size() >= 2) break;
    end
    chk("mid_stream_timeout", 0, 32'(k < 40), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("async_reset_zero", g,
          32'(|{d_in_ready[g], d_we[g], d_aw[g], d_di[g], d_re[g], d_ar[g],
                d_ov[g], d_od[g], d_ol[g], d_busy[g], d_done[g]}), 32'd0);
    end
    chk("popped_before_reset", 0, 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      chk("popped_px0", 0, 32'(got_q[0]), 32'hC1);
      chk("popped_px1", 0, 32'(got_q[1]), 32'hC2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_logs();
    reset_dut();
    run_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 0, 1'b0);
    run_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 0, 1'b0);
    run_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 5, 1'b0);
    run_frame(8'h5A, 8'hA5, 8'h0F, 8'hF0, 1'b0, 0, 1'b1);
    reset_mid_stream();
    run_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
